div_share_ctrl: RTL
===================

Name: div_share_ctrl

Overview:
- Shares one iterative radix-2 restoring divider (one quotient bit per clock) among NREQ requesters.
- Round-robin arbitration over valid/ready request ports.
- Runs the WIDTH-cycle shift-subtract sequence and returns quotient, remainder, divide-by-zero flag and requester ID on one valid/ready response port.
- Sits between the issuing units and the divide datapath; it is the only owner of the divider.

Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 32, operand/result width
- IDW, 2, width of rsp_id; must be at least clog2(NREQ)

Ports:
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; at most one bit high
- req_a  in  NREQ*WIDTH  dividends; requester i occupies [i*WIDTH +: WIDTH]
- req_b  in  NREQ*WIDTH  divisors; same packing
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  IDW  index of the requester that owns the result
- rsp_quot  out  WIDTH  unsigned quotient
- rsp_rem  out  WIDTH  unsigned remainder
- rsp_dbz  out  1  divisor was zero
- busy  out  1  high in CALC and DONE

Behaviour:
- Reset (async assert, sync release): state=IDLE, rsp_valid=0, rsp_id=0, rsp_quot=0, rsp_rem=0, rsp_dbz=0, busy=0, req_ready=0, rr_ptr=NREQ-1, iteration counter=0.
- Reset asserted mid-operation aborts the operation immediately; no response is produced.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - grant = first i with req_valid[i]=1, searching rr_ptr+1, rr_ptr+2, ... modulo NREQ.
  - req_ready[grant] is driven combinationally high; all other req_ready bits are 0.
  - Handshake edge: latch a/b of the granted requester and its ID, set rr_ptr=grant, counter=0, go to CALC.
  - No req_valid: stay in IDLE, all req_ready=0.
- CALC:
  - Datapath register {rem,quot}: 2*WIDTH bits, loaded {0,a} at the handshake.
  - Each cycle: shift left by 1; if upper half >= b, then upper -= b and bit0 = 1.
  - Runs exactly WIDTH cycles. After the WIDTH-th edge, go to DONE and set rsp_valid=1.
  - Latency: handshake at edge E0 gives rsp_valid high after edge E0+WIDTH (32 cycles at default).
  - req_ready=0 throughout.
- DONE:
  - rsp_* outputs held stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_valid & rsp_ready: rsp_valid=0, go to IDLE.
  - Minimum issue interval is WIDTH+2 cycles.
  - rsp_quot/rsp_rem keep their last values after the response handshake until the next DONE.
  - A rsp_ready that is high before DONE is ignored.
- Arithmetic:
  - Unsigned.
  - b=0: rsp_quot=all ones, rsp_rem=a, rsp_dbz=1. This is the natural result of the iteration; no special path.
  - rsp_dbz is computed from the latched b at the handshake.
- Requester obligations: hold req_valid, req_a and req_b stable until req_ready. Dropping req_valid before grant is legal; that requester is simply skipped.
- Fairness: while a requester keeps req_valid asserted, it is served within NREQ operations.

Test Plan:
- Single op: req 0 sends a=100, b=7, rsp_ready tied 1 -> rsp_valid high exactly 32 cycles after the handshake; quot=14, rem=2, dbz=0, id=0.
- Divide by zero: req 2 sends a=0x12345678, b=0 -> quot=0xFFFFFFFF, rem=0x12345678, dbz=1, id=2.
- Round-robin: all 4 req_valid held high, each with distinct operands -> grants in order 0,1,2,3,0, each with the correct id/quot/rem; req_ready is one-hot.
- Backpressure: a=0xFFFFFFFF, b=1; rsp_ready held low 10 cycles after rsp_valid -> outputs stable (quot=0xFFFFFFFF, rem=0); no new req_ready until the response handshake.
- Reset mid-CALC: assert rst_n=0 at iteration 15 -> all outputs return to reset values without waiting for a clock edge; after release, req 0 is granted first and returns the correct result for a fresh a=81, b=9 (quot=9, rem=0).
- Edge values: a=5, b=9 -> quot=0, rem=5; a=0x80000000, b=0x80000000 -> quot=1, rem=0.

Source files
------------

// File: rtl/div_share_ctrl.sv
// Shared iterative radix-2 restoring divider with round-robin arbitration
// among NREQ valid/ready requesters and a single valid/ready response port.
module div_share_ctrl #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_quot,
    output logic [WIDTH-1:0]      rsp_rem,
    output logic                  rsp_dbz,
    output logic                  busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [PW-1:0]        rr_ptr;
    logic [PW-1:0]        grant;
    logic                 grant_vld;
    logic [PW-1:0]        id_q;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   work;
    logic [2*WIDTH-1:0]   work_next;
    logic [WIDTH-1:0]     b_q;
    logic                 dbz_q;
    logic                 take;
    logic                 last_iter;
    logic [WIDTH:0]       up_sh;
    logic [WIDTH:0]       diff;

    // Round-robin search: first valid requester after rr_ptr, wrapping.
    // Scanning from the farthest offset down lets the nearest one win.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        grant     = '0;
        grant_vld = 1'b0;
        for (int unsigned k = NREQ; k > 0; k--) begin
            idx = (32'(rr_ptr) + k) % NREQ;
            if (req_valid[idx]) begin
                grant     = PW'(idx);
                grant_vld = 1'b1;
            end
        end
    end

    assign take      = (state == IDLE) && grant_vld;
    assign last_iter = (cnt == CW'(WIDTH - 1));

    // One-hot accept toward the granted requester, only while idle and out of reset.
    always_comb begin
        req_ready = '0;
        if ((state == IDLE) && grant_vld && rst_n) begin
            req_ready[grant] = 1'b1;
        end
    end

    // One shift-subtract step; the bit shifted out of the remainder is kept
    // as a carry so the compare stays exact for divisors above 2^(WIDTH-1).
    always_comb begin
        up_sh     = work[2*WIDTH-1:WIDTH-1];
        diff      = up_sh - {1'b0, b_q};
        work_next = {work[2*WIDTH-2:0], 1'b0};
        if (up_sh >= {1'b0, b_q}) begin
            work_next[2*WIDTH-1:WIDTH] = diff[WIDTH-1:0];
            work_next[0]               = 1'b1;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (take)      state_next = CALC;
            CALC:    if (last_iter) state_next = DONE;
            DONE:    if (rsp_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operand capture, iteration and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr   <= PW'(NREQ - 1);
            cnt      <= '0;
            work     <= '0;
            b_q      <= '0;
            dbz_q    <= 1'b0;
            id_q     <= '0;
            rsp_id   <= '0;
            rsp_quot <= '0;
            rsp_rem  <= '0;
            rsp_dbz  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        work   <= {{WIDTH{1'b0}}, req_a[grant*WIDTH +: WIDTH]};
                        b_q    <= req_b[grant*WIDTH +: WIDTH];
                        dbz_q  <= (req_b[grant*WIDTH +: WIDTH] == '0);
                        id_q   <= grant;
                        rr_ptr <= grant;
                        cnt    <= '0;
                    end
                end
                CALC: begin
                    work <= work_next;
                    cnt  <= cnt + CW'(1);
                    if (last_iter) begin
                        rsp_quot <= work_next[WIDTH-1:0];
                        rsp_rem  <= work_next[2*WIDTH-1:WIDTH];
                        rsp_id   <= IDW'(id_q);
                        rsp_dbz  <= dbz_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid = (state == DONE);
    assign busy      = (state != IDLE);

endmodule
